// File: rtl/frv_pipeline_buffer.sv
// DEPTH-entry elastic pipeline stage register with registered valid/busy.
// Upstream and downstream stalls are decoupled: outputs decode only from registered state.
module frv_pipeline_buffer #(
  parameter  int RLEN  = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic [RLEN-1:0] i_data,
  input  logic            i_valid,
  output logic            o_busy,
  output logic [RLEN-1:0] mr_data,
  input  logic            flush,
  input  logic [RLEN-1:0] flush_dat,
  output logic [RLEN-1:0] o_data,
  output logic            o_valid,
  input  logic            i_busy,
  output logic [CW-1:0]   o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RLEN-1:0] entry [DEPTH];
  logic [PW-1:0]   rp;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp_nxt;
  logic [PW-1:0]   wp_nxt;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  assign o_valid = (cnt != '0);
  assign o_busy  = (cnt == CW'(DEPTH));
  assign o_count = cnt;
  assign o_data  = entry[rp];

  assign push = i_valid && !o_busy;
  assign pop  = o_valid && !i_busy;

  // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
  assign rp_nxt = (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
  assign wp_nxt = (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= '0;
      end
      rp      <= '0;
      wp      <= '0;
      cnt     <= '0;
      mr_data <= '0;
    end else if (flush) begin
      // Park flush_dat in slot 0 so o_data shows it while the buffer is empty.
      entry[0] <= flush_dat;
      mr_data  <= flush_dat;
      rp       <= '0;
      wp       <= '0;
      cnt      <= '0;
    end else begin
      if (push) begin
        entry[wp] <= i_data;
        wp        <= wp_nxt;
        mr_data   <= i_data;
      end
      if (pop) begin
        rp <= rp_nxt;
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: doc/frv_pipeline_buffer.md
# frv_pipeline_buffer

Parametrised, fully-handshaked pipeline stage register for the frv core. It replaces the pass-through stage register with a DEPTH-entry elastic buffer that decouples upstream and downstream stall signals. There is no combinational path from `i_busy` to `o_busy` and none from `i_valid` to `o_valid`. It sits between any two pipeline stages, with flush and flush-data semantics compatible with the existing stage register.

## Interface
- `RLEN`, 8: width of each buffered entry, in bits.
- `DEPTH`, 2: number of entries, legal range 1..8; non-power-of-two values are legal.
- `CW`, `$clog2(DEPTH+1)`: width of `o_count`; derived, never overridden.

Ports:
- `g_clk`  in  1  global clock. Reset is `g_resetn`, synchronous, active-low; clock is `g_clk`.
- `g_resetn`  in  1  synchronous active-low reset.
- `i_data`  in  RLEN  data from stage N.
- `i_valid`  in  1  `i_data` valid.
- `o_busy`  out  1  buffer cannot accept this cycle (registered).
- `mr_data`  out  RLEN  most recently accepted (or flushed) entry.
- `flush`  in  1  discard all buffered contents.
- `flush_dat`  in  RLEN  value loaded on flush.
- `o_data`  out  RLEN  head entry, to stage N+1.
- `o_valid`  out  1  `o_data` valid (registered).
- `i_busy`  in  1  stage N+1 stalled.
- `o_count`  out  CW  number of occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH x RLEN entry array, read pointer `rp`, write pointer `wp`, occupancy counter `cnt`.
- Pointers increment modulo DEPTH: value DEPTH-1 wraps to 0. Explicit compare, no power-of-two masking.
- Push condition: `i_valid && !o_busy`. Writes `i_data` to entry[wp], advances `wp`, updates `mr_data <= i_data`.
- Pop condition: `o_valid && !i_busy`. Advances `rp`.
- `cnt` update: push only, +1; pop only, −1; push and pop together, unchanged; neither, unchanged.
- `o_valid = (cnt != 0)` and `o_busy = (cnt == DEPTH)`. Both are decoded from the registered `cnt`.
- Full and popping in the same cycle: the push is still refused, because `o_busy` is already high. There is no pass-through when full.
- Empty and pushing: no bypass. Data appears on `o_data` with `o_valid` one cycle later.
- `o_data = entry[rp]` at all times, including when `o_valid` is 0.
- Flush has highest priority below reset. On a flush cycle:
  - `rp`, `wp` and `cnt` reset to 0.
  - entry[0] is set to `flush_dat`.
  - `mr_data` is set to `flush_dat`.
  - Any simultaneous push or pop is discarded.
- After a flush, `o_data = flush_dat`, `o_valid = 0` and `o_busy = 0`.
- Reset sets all entries, `mr_data`, `rp`, `wp` and `cnt` to 0. Outputs after reset: `o_data = 0`, `mr_data = 0`, `o_valid = 0`, `o_busy = 0`, `o_count = 0`.
- Reset asserted mid-operation wins over flush, push and pop in the same cycle.
- Upstream obligation: `i_data` is held stable while `i_valid && o_busy`.
- Downstream guarantee: `o_data` and `o_valid` stay stable while `o_valid && i_busy` and no flush occurs.
- DEPTH=1 is legal. It sustains at most one transfer every 2 cycles, because a full buffer blocks push.
- With DEPTH>=2, sustained throughput is 1 entry per cycle.

## Timing
- Latency from input acceptance to output valid: 1 cycle.
- `o_busy` rises the cycle after the push that fills the buffer. It falls the cycle after the first pop from full.
- Flush takes effect at the next clock edge. `o_valid` is 0 in the cycle after the flush.
- All outputs are registered or decoded from registers. No input-to-output combinational path exists.
- `cnt` never exceeds DEPTH and never underflows, by construction of the push and pop conditions.

## Test plan
- **Reset state.** Assert `g_resetn = 0` for 2 cycles while `i_valid = 1`, `flush = 1`. Required after release: `o_valid = 0`, `o_busy = 0`, `o_count = 0`, `o_data = 0`, `mr_data = 0`.
- **Fill and drain.** DEPTH=2, RLEN=8. Hold `i_busy = 1` and push 0xA1, 0xA2, 0xA3.
  - Required: `o_busy = 1` after the second push, 0xA3 held off, `o_count = 2`, `mr_data = 0xA2`.
  - Then release `i_busy`. Required order on `o_data`: 0xA1, 0xA2, 0xA3. `o_busy` drops one cycle after the first pop.
- **Streaming.** DEPTH=2 with `i_busy = 0`. Push 16 consecutive values 0x00..0x0F. Required: output matches the input order one cycle late, one value per cycle, `o_busy` never asserted.
- **Wrap-around.** DEPTH=3. Randomly toggle `i_valid` and `i_busy` for 200 cycles against a scoreboard. Required: no loss, no duplication or reordering, `o_count` equals the model occupancy, pointers wrap 2→0.
- **Flush priority.** DEPTH=4 with 3 entries held. Assert `flush` with `flush_dat = 0x5C`, `i_valid = 1`, `i_data = 0x77`, `i_busy = 0`. Required next cycle: `o_valid = 0`, `o_count = 0`, `o_data = 0x5C`, `mr_data = 0x5C`, and 0x77 is never output.
- **DEPTH=1 throughput.** Push continuously with `i_busy = 0`. Required: `o_busy` alternates, and exactly one transfer is accepted every 2 cycles.
